// File: rtl/pong_frame_renderer_if.sv
// Pixel/position bus between game-state logic, the renderer and the VGA output stage.
// The renderer takes the slave side; the game/timing source takes the master side.
interface pong_frame_renderer_if #(
  parameter int COLOR_WIDTH = 4
);
  logic                       frame_start;
  logic                       pos_valid;
  logic [9:0]                 left_paddle_y;
  logic [9:0]                 right_paddle_y;
  logic [9:0]                 ball_x;
  logic [9:0]                 ball_y;
  logic                       pix_valid;
  logic [9:0]                 pix_x;
  logic [9:0]                 pix_y;
  logic [3*COLOR_WIDTH-1:0]   rgb;
  logic                       rgb_valid;

  modport master (
    output frame_start, pos_valid, left_paddle_y, right_paddle_y, ball_x, ball_y,
    output pix_valid, pix_x, pix_y,
    input  rgb, rgb_valid
  );

  modport slave (
    input  frame_start, pos_valid, left_paddle_y, right_paddle_y, ball_x, ball_y,
    input  pix_valid, pix_x, pix_y,
    output rgb, rgb_valid
  );
endinterface

// File: rtl/pong_frame_renderer.sv
// Per-frame snapshot of paddle/ball positions and a 2-stage pixel colour pipeline.
// Stage 1 registers hit flags, stage 2 registers the priority-muxed colour.
module pong_frame_renderer #(
  parameter int TOTAL_WIDTH               = 640,
  parameter int TOTAL_HEIGHT              = 480,
  parameter int PADDLE_DISTANCE_FROM_EDGE = 40,
  parameter int PADDLE_HEIGHT             = 100,
  parameter int PADDLE_WIDTH              = 15,
  parameter int BALL_SIDE_SIZE            = 24,
  parameter int COLOR_WIDTH               = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  pong_frame_renderer_if.slave bus
);

  localparam logic [9:0]  PADDLE_Y_MAX = 10'(TOTAL_HEIGHT - PADDLE_HEIGHT);
  localparam logic [9:0]  BALL_X_MAX   = 10'(TOTAL_WIDTH - BALL_SIDE_SIZE);
  localparam logic [9:0]  BALL_Y_MAX   = 10'(TOTAL_HEIGHT - BALL_SIDE_SIZE);
  localparam logic [9:0]  PADDLE_Y_RST = 10'((TOTAL_HEIGHT - PADDLE_HEIGHT) / 2);
  localparam logic [9:0]  BALL_X_RST   = 10'((TOTAL_WIDTH - BALL_SIDE_SIZE) / 2);
  localparam logic [9:0]  BALL_Y_RST   = 10'((TOTAL_HEIGHT - BALL_SIDE_SIZE) / 2);

  localparam logic [10:0] SCR_W    = 11'(TOTAL_WIDTH);
  localparam logic [10:0] SCR_H    = 11'(TOTAL_HEIGHT);
  localparam logic [10:0] LEFT_X0  = 11'(PADDLE_DISTANCE_FROM_EDGE);
  localparam logic [10:0] LEFT_X1  = 11'(PADDLE_DISTANCE_FROM_EDGE + PADDLE_WIDTH - 1);
  localparam logic [10:0] RIGHT_X0 = 11'(TOTAL_WIDTH - PADDLE_DISTANCE_FROM_EDGE - PADDLE_WIDTH);
  localparam logic [10:0] RIGHT_X1 = 11'(TOTAL_WIDTH - PADDLE_DISTANCE_FROM_EDGE - 1);
  localparam logic [10:0] PAD_SPAN = 11'(PADDLE_HEIGHT - 1);
  localparam logic [10:0] BALL_SPAN = 11'(BALL_SIDE_SIZE - 1);
  localparam logic [10:0] LINE_X0  = 11'(TOTAL_WIDTH / 2 - 1);
  localparam logic [10:0] LINE_X1  = 11'(TOTAL_WIDTH / 2);

  localparam logic [COLOR_WIDTH-1:0] C_MAX  = '1;
  localparam logic [COLOR_WIDTH-1:0] C_ZERO = '0;
  localparam logic [COLOR_WIDTH-1:0] C_HALF = {1'b1, {(COLOR_WIDTH-1){1'b0}}};

  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  logic [9:0] left_y, right_y, ball_x, ball_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_y  <= PADDLE_Y_RST;
      right_y <= PADDLE_Y_RST;
      ball_x  <= BALL_X_RST;
      ball_y  <= BALL_Y_RST;
    end else if (bus.frame_start && bus.pos_valid) begin
      left_y  <= clamp(bus.left_paddle_y, PADDLE_Y_MAX);
      right_y <= clamp(bus.right_paddle_y, PADDLE_Y_MAX);
      ball_x  <= clamp(bus.ball_x, BALL_X_MAX);
      ball_y  <= clamp(bus.ball_y, BALL_Y_MAX);
    end
  end

  // Hit tests read the registered snapshot, so a pixel arriving with frame_start sees the old one.
  logic [10:0] x11, y11, ly11, ry11, bx11, by11;
  logic        on_screen, ball_hit, paddle_hit, line_hit;

  always_comb begin
    x11  = {1'b0, bus.pix_x};
    y11  = {1'b0, bus.pix_y};
    ly11 = {1'b0, left_y};
    ry11 = {1'b0, right_y};
    bx11 = {1'b0, ball_x};
    by11 = {1'b0, ball_y};
    on_screen  = (x11 < SCR_W) && (y11 < SCR_H);
    ball_hit   = (x11 >= bx11) && (x11 <= bx11 + BALL_SPAN) &&
                 (y11 >= by11) && (y11 <= by11 + BALL_SPAN);
    paddle_hit = ((x11 >= LEFT_X0) && (x11 <= LEFT_X1) &&
                  (y11 >= ly11) && (y11 <= ly11 + PAD_SPAN)) ||
                 ((x11 >= RIGHT_X0) && (x11 <= RIGHT_X1) &&
                  (y11 >= ry11) && (y11 <= ry11 + PAD_SPAN));
    line_hit   = ((x11 == LINE_X0) || (x11 == LINE_X1)) && !bus.pix_y[4];
  end

  logic s1_valid, s1_ball, s1_paddle, s1_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_ball   <= 1'b0;
      s1_paddle <= 1'b0;
      s1_line   <= 1'b0;
    end else begin
      s1_valid  <= bus.pix_valid;
      s1_ball   <= bus.pix_valid && on_screen && ball_hit;
      s1_paddle <= bus.pix_valid && on_screen && paddle_hit;
      s1_line   <= bus.pix_valid && on_screen && line_hit;
    end
  end

  logic [3*COLOR_WIDTH-1:0] colour;

  always_comb begin
    colour = '0;
    if (s1_ball)        colour = {C_MAX, C_ZERO, C_ZERO};
    else if (s1_paddle) colour = {C_MAX, C_MAX, C_MAX};
    else if (s1_line)   colour = {C_HALF, C_HALF, C_HALF};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rgb       <= '0;
      bus.rgb_valid <= 1'b0;
    end else begin
      bus.rgb       <= colour;
      bus.rgb_valid <= s1_valid;
    end
  end

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Directed bench for pong_frame_renderer: snapshot, clamping, priority, latency and reset.
module tb_pong_frame_renderer;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  pong_frame_renderer_if #(.COLOR_WIDTH(4)) bus ();

  pong_frame_renderer #(
    .TOTAL_WIDTH(640), .TOTAL_HEIGHT(480), .PADDLE_DISTANCE_FROM_EDGE(40),
    .PADDLE_HEIGHT(100), .PADDLE_WIDTH(15), .BALL_SIDE_SIZE(24), .COLOR_WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge; presents one pixel and checks the 2-cycle latency.
  task automatic send_pix(input string tag, input int x, input int y, input logic [11:0] exp_rgb);
    bus.pix_valid = 1'b1;
    bus.pix_x     = 10'(x);
    bus.pix_y     = 10'(y);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    check_eq({tag, "_early_valid"}, {15'd0, bus.rgb_valid}, 16'd0);
    check_eq({tag, "_early_rgb"}, {4'd0, bus.rgb}, 16'd0);
    @(negedge clk);
    check_eq({tag, "_valid"}, {15'd0, bus.rgb_valid}, 16'd1);
    check_eq({tag, "_rgb"}, {4'd0, bus.rgb}, {4'd0, exp_rgb});
  endtask

  task automatic snapshot(input logic pv, input int l, input int r, input int bx, input int by);
    bus.frame_start    = 1'b1;
    bus.pos_valid      = pv;
    bus.left_paddle_y  = 10'(l);
    bus.right_paddle_y = 10'(r);
    bus.ball_x         = 10'(bx);
    bus.ball_y         = 10'(by);
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.pos_valid   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.pos_valid = 1'b0;
    bus.left_paddle_y = '0;
    bus.right_paddle_y = '0;
    bus.ball_x = '0;
    bus.ball_y = '0;
    bus.pix_valid = 1'b0;
    bus.pix_x = '0;
    bus.pix_y = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_valid", {15'd0, bus.rgb_valid}, 16'd0);
    check_eq("reset_rgb", {4'd0, bus.rgb}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send_pix("rst_paddle", 47, 240, 12'hFFF);

    snapshot(1'b1, 190, 190, 100, 100);
    send_pix("ball_tl", 100, 100, 12'hF00);
    send_pix("ball_br", 123, 123, 12'hF00);
    send_pix("ball_out", 124, 100, 12'h000);

    snapshot(1'b1, 190, 190, 40, 200);
    send_pix("ball_over_paddle", 45, 210, 12'hF00);

    snapshot(1'b1, 450, 190, 100, 100);
    send_pix("clamp_bottom", 40, 479, 12'hFFF);
    send_pix("clamp_above", 40, 379, 12'h000);

    // Snapshot and pixel in the same cycle, then the same pixel again.
    bus.frame_start = 1'b1; bus.pos_valid = 1'b1;
    bus.left_paddle_y = 10'd0; bus.right_paddle_y = 10'd190;
    bus.ball_x = 10'd100; bus.ball_y = 10'd100;
    bus.pix_valid = 1'b1; bus.pix_x = 10'd50; bus.pix_y = 10'd5;
    @(negedge clk);
    bus.frame_start = 1'b0; bus.pos_valid = 1'b0;
    @(negedge clk);
    bus.pix_valid = 1'b0;
    check_eq("same_cycle_valid", {15'd0, bus.rgb_valid}, 16'd1);
    check_eq("same_cycle_old", {4'd0, bus.rgb}, 16'h0000);
    @(negedge clk);
    check_eq("next_cycle_valid", {15'd0, bus.rgb_valid}, 16'd1);
    check_eq("next_cycle_new", {4'd0, bus.rgb}, 16'h0FFF);
    @(negedge clk);

    snapshot(1'b0, 300, 300, 500, 110);
    send_pix("hold_ball_old", 110, 110, 12'hF00);
    send_pix("hold_ball_new", 510, 110, 12'h000);
    send_pix("hold_left", 50, 5, 12'hFFF);

    send_pix("line_on", 320, 15, 12'h888);
    send_pix("line_off", 320, 16, 12'h000);
    send_pix("line_left", 319, 0, 12'h888);
    send_pix("line_miss", 318, 0, 12'h000);
    send_pix("right_edge_in", 599, 200, 12'hFFF);
    send_pix("right_edge_out", 600, 200, 12'h000);
    send_pix("right_bot_in", 585, 289, 12'hFFF);
    send_pix("right_bot_out", 585, 290, 12'h000);
    send_pix("offscreen_x", 700, 10, 12'h000);
    send_pix("offscreen_y", 320, 480, 12'h000);

    snapshot(1'b1, 0, 190, 1000, 1000);
    send_pix("ball_clamp_in", 639, 479, 12'hF00);
    send_pix("ball_clamp_out", 615, 470, 12'h000);
    send_pix("ball_clamp_top", 616, 455, 12'h000);

    // Continuous stream, then reset lands mid-stream.
    bus.pix_valid = 1'b1; bus.pix_x = 10'd47; bus.pix_y = 10'd10;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("stream_valid", {15'd0, bus.rgb_valid}, 16'd1);
    check_eq("stream_rgb", {4'd0, bus.rgb}, 16'h0FFF);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", {15'd0, bus.rgb_valid}, 16'd0);
    check_eq("midrst_rgb", {4'd0, bus.rgb}, 16'd0);
    bus.pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_pix("post_rst_paddle", 47, 240, 12'hFFF);
    send_pix("post_rst_snap", 47, 10, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
